mb_frame_tx: RTL and testbench
==============================

// Module: mb_frame_tx
// PURPOSE
//  Modbus RTU frame transmitter. Sits directly upstream of the UART byte
//  transmitter: takes payload bytes as a valid/ready stream, issues them one at
//  a time (data + 1-cycle strobe, waits for send-finish pulse), appends CRC16
//  (low byte first), then enforces the T3.5 inter-frame silence.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency, Hz
//  BAUD     9600        line rate; character = 10 bits (start, 8 data, stop)
//  MAX_LEN  256         max frame length incl. 2 CRC bytes (payload <= MAX_LEN-2)
// PORTS
//  clk             in   1  system clock
//  rst_n           in   1  reset, asynchronous, active-low
//  in_data         in   8  payload byte
//  in_valid        in   1  in_data valid
//  in_last         in   1  qualifies final payload byte of the frame
//  in_ready        out  1  byte accepted when in_valid && in_ready
//  tx_data         out  8  byte to the UART transmitter; held until tx_send_finish
//  tx_data_f       out  1  1-cycle start strobe to the UART transmitter
//  tx_send_finish  in   1  1-cycle pulse from the UART transmitter: byte done
//  busy            out  1  state != IDLE
//  frame_done      out  1  1-cycle pulse: frame + gap complete
//  err_len         out  1  1-cycle pulse: payload truncated at MAX_LEN-2
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=0 during reset, 1 after; tx_data=0, tx_data_f=0,
//   busy=0, frame_done=0, err_len=0, crc=16'hFFFF, byte count=0, gap count=0.
//  States: IDLE, NEXT, ISSUE, WAIT, CRC_LO, CRC_HI, GAP.
//  IDLE/NEXT: in_ready=1. On accept: tx_data<=in_data, crc<=crc16_upd(crc,byte)
//   (IDLE seeds crc=FFFF first), cnt++, last_r<=in_last, -> ISSUE.
//  ISSUE: tx_data_f=1 for exactly one cycle (accept at edge N -> strobe in
//   cycle N+1), -> WAIT.
//  WAIT: hold tx_data; on tx_send_finish: last_r ? ->CRC_LO : ->NEXT.
//   tx_send_finish outside WAIT is ignored. No strobe ever issued while waiting.
//  CRC_LO / CRC_HI: load tx_data=crc[7:0] / crc[15:8], strobe 1 cycle, wait
//   finish (same ISSUE/WAIT sub-sequence); CRC frozen during CRC phase.
//  CRC16: poly 16'hA001 reflected, init 16'hFFFF, byte-wise, no final XOR.
//  Length: accepting byte number MAX_LEN-2 with in_last=0 forces last_r=1 and
//   pulses err_len in the accept+1 cycle; later bytes wait for next frame.
//  GAP: count GAP_CYC cycles after CRC_HI finish, then frame_done=1 one cycle,
//   -> IDLE. in_ready=0 throughout (back-to-back frames wait out the gap).
//  GAP_CYC = (BAUD > 19200) ? CLK_HZ*7/4000 (1.75 ms)
//          : (CLK_HZ/BAUD)*35   (3.5 chars x 10 bits); counter width via $clog2.
//  Reset mid-frame: everything returns to reset values immediately; partial
//   frame is abandoned (no CRC sent).
// CONFIGURATION
//  MB_FRAME_GAP_EN defined: GAP state as above.
//  Undefined: GAP state removed; frame_done pulses the cycle after the CRC_HI
//   tx_send_finish and in_ready returns to 1 that same cycle.
// STRUCTURE
//  mb_pkg: CRC_POLY=16'hA001, CRC_INIT=16'hFFFF, CHAR_BITS=10, state enum.
//  Sub-module mb_crc16: combinational one-byte update (crc_in, byte -> crc_out).
// TESTING
//  01 03 00 00 00 01 (last on 01) -> tx bytes 01 03 00 00 00 01 84 0A, 8 strobes,
//   each strobe only after prior finish; frame_done once.
//  Single byte 0x55 with in_last -> 55, CRC lo, CRC hi; CRC matches mb_crc16 model.
//  CLK_HZ=1000, BAUD=100, gap on -> frame_done exactly 350 cycles after last
//   finish; in_valid held high meanwhile -> in_ready stays 0.
//  MAX_LEN=8, 7 bytes no in_last -> 6 payload + 2 CRC sent, err_len pulses once,
//   7th byte starts next frame.
//  rst_n low during WAIT of byte 3 -> outputs at reset values, no CRC emitted;
//   new frame after release is correct.
//  Spurious tx_send_finish in IDLE/GAP -> no state change, no strobe.

Source files
------------

// File: rtl/mb_frame_tx_pkg.sv
// Shared constants, state encoding and gap-length helper for the Modbus RTU frame transmitter.
// The GAP state exists only when MB_FRAME_GAP_EN is defined.
package mb_frame_tx_pkg;

  localparam logic [15:0] CRC_POLY  = 16'hA001;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam int unsigned CHAR_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEXT   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5
`ifdef MB_FRAME_GAP_EN
    ,
    ST_GAP    = 3'd6
`endif
  } state_e;

  // T3.5 silence in clock cycles; fixed 1.75 ms above 19200 baud.
  function automatic int unsigned gap_cycles(input int unsigned clk_hz, input int unsigned baud);
    if (baud > 19200) return (clk_hz * 7) / 4000;
    else              return (clk_hz / baud) * ((CHAR_BITS * 7) / 2);
  endfunction

endpackage

// File: rtl/mb_frame_tx_if.sv
// Payload stream and UART byte-transmitter handshake for the frame transmitter.
interface mb_frame_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_data_f;
  logic       tx_send_finish;

  modport master (
    output in_data, in_valid, in_last, tx_send_finish,
    input  in_ready, tx_data, tx_data_f
  );

  modport slave (
    input  in_data, in_valid, in_last, tx_send_finish,
    output in_ready, tx_data, tx_data_f
  );
endinterface

// File: rtl/mb_frame_tx_crc16.sv
// Combinational one-byte Modbus CRC16 update (reflected poly A001, no final XOR).
module mb_frame_tx_crc16
  import mb_frame_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out_c
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ CRC_POLY) : (acc >> 1);
    end
    crc_out_c = acc;
  end

endmodule

// File: rtl/mb_frame_tx.sv
// Modbus RTU frame transmitter: payload bytes -> UART byte sender, appends CRC16, then T3.5 silence.
// Define MB_FRAME_GAP_EN to enforce the inter-frame gap; otherwise the frame ends right after CRC_HI.
module mb_frame_tx
  import mb_frame_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 9600,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  mb_frame_tx_if.slave bus,
  output logic         busy,
  output logic         frame_done,
  output logic         err_len
);

  localparam int unsigned CNT_W   = $clog2(MAX_LEN);
  localparam int unsigned MAX_PAY = MAX_LEN - 2;

  if (MAX_LEN < 3 || BAUD == 0 || CLK_HZ < BAUD * CHAR_BITS) begin : g_cfg_err
    $error("mb_frame_tx: unsupported CLK_HZ/BAUD/MAX_LEN combination");
  end

`ifdef MB_FRAME_GAP_EN
  localparam int unsigned GAP_CYC = gap_cycles(CLK_HZ, BAUD);
  localparam int unsigned GAP_W   = $clog2(GAP_CYC);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  state_e      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_f_q, tx_f_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        last_q, last_d;

  logic        accept_c;
  logic [15:0] crc_seed_c;
  logic [15:0] crc_next_c;
  logic [CNT_W-1:0] cnt_inc_c;

  assign accept_c   = bus.in_valid && in_ready_q;
  assign crc_seed_c = (state_q == ST_IDLE) ? CRC_INIT : crc_q;
  assign cnt_inc_c  = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);

  mb_frame_tx_crc16 u_crc (
    .crc_in    (crc_seed_c),
    .data      (bus.in_data),
    .crc_out_c (crc_next_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_f_d     = 1'b0;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
`ifdef MB_FRAME_GAP_EN
    gap_d      = gap_q;
`endif

    case (state_q)
      ST_IDLE, ST_NEXT: begin
        in_ready_d = 1'b1;
        if (accept_c) begin
          tx_data_d  = bus.in_data;
          crc_d      = crc_next_c;
          cnt_d      = cnt_inc_c;
          last_d     = bus.in_last;
          // Reaching the payload limit closes the frame even without in_last.
          if (!bus.in_last && cnt_inc_c == CNT_W'(MAX_PAY)) begin
            last_d = 1'b1;
            err_d  = 1'b1;
          end
          tx_f_d     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_send_finish) begin
          if (last_q) begin
            tx_data_d = crc_q[7:0];
            tx_f_d    = 1'b1;
            state_d   = ST_CRC_LO;
          end else begin
            in_ready_d = 1'b1;
            state_d    = ST_NEXT;
          end
        end
      end
      // CRC states strobe on entry; a finish during the strobe cycle is ignored.
      ST_CRC_LO: begin
        if (bus.tx_send_finish && !tx_f_q) begin
          tx_data_d = crc_q[15:8];
          tx_f_d    = 1'b1;
          state_d   = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (bus.tx_send_finish && !tx_f_q) begin
`ifdef MB_FRAME_GAP_EN
          gap_d   = '0;
          state_d = ST_GAP;
`else
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = ST_IDLE;
`endif
        end
      end
`ifdef MB_FRAME_GAP_EN
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 2)) begin
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_f_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      crc_q      <= CRC_INIT;
      cnt_q      <= '0;
      last_q     <= 1'b0;
`ifdef MB_FRAME_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_f_q     <= tx_f_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
`ifdef MB_FRAME_GAP_EN
      gap_q      <= gap_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_data_f = tx_f_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign err_len       = err_q;

endmodule

// File: tb/tb_mb_frame_tx.sv
// Bench for mb_frame_tx: frame-level model (split, truncate, CRC, gap timing) vs cycle-by-cycle DUT outputs.
module tb_mb_frame_tx;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned BAUD    = 100;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned MAX_PAY = MAX_LEN - 2;
`ifdef MB_FRAME_GAP_EN
  localparam int DONE_LAT = int'((CLK_HZ / BAUD) * 35);
`else
  localparam int DONE_LAT = 1;
`endif

  typedef struct { logic [7:0] d; bit l; } beat_t;
  typedef struct { logic [7:0] data; bit err; bit fend; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, frame_done, err_len;
  int   cyc = 0;

  mb_frame_tx_if bus ();

  mb_frame_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] crc_fn(input logic [7:0] b[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  beat_t plan[$];
  exp_t  exp_q[$];
  logic [7:0] tx_log[$];
  int n_frames_exp = 0, n_err_exp = 0, n_fd_seen = 0, n_err_seen = 0;

  // Split the beat stream into frames, truncating at MAX_PAY, and append each frame's CRC.
  task automatic build_model();
    logic [7:0] buff[$];
    logic [15:0] c;
    foreach (plan[i]) begin
      buff.push_back(plan[i].d);
      if (plan[i].l || buff.size() == MAX_PAY) begin
        c = crc_fn(buff);
        foreach (buff[j])
          exp_q.push_back('{data: buff[j], err: (j == buff.size() - 1) && !plan[i].l, fend: 1'b0});
        exp_q.push_back('{data: c[7:0],  err: 1'b0, fend: 1'b0});
        exp_q.push_back('{data: c[15:8], err: 1'b0, fend: 1'b1});
        n_frames_exp++;
        if (!plan[i].l) n_err_exp++;
        buff.delete();
      end
    end
  endtask

  // Checker and UART-side responder
  bit   chk_en = 1'b0;
  bit   outstanding = 1'b0;
  bit   cur_end = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  int   delay = 0;
  int   fin_cyc = -100000;
  int   done_due = -100000;
  exp_t ck_e;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame_done", 16'(frame_done), 16'(cyc == done_due));
      if (frame_done) n_fd_seen++;
`ifndef MB_FRAME_GAP_EN
      if (cyc == done_due) chk("in_ready_at_done", 16'(bus.in_ready), 16'd1);
`endif
      if (err_len) n_err_seen++;
      if (bus.tx_data_f) begin
        chk("strobe_before_finish", 16'(outstanding), 16'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 16'(bus.tx_data), 16'hFFFF);
        end else begin
          ck_e = exp_q.pop_front();
          chk("tx_data", 16'(bus.tx_data), 16'(ck_e.data));
          chk("err_len_on_strobe", 16'(err_len), 16'(ck_e.err));
          cur_byte = ck_e.data;
          cur_end  = ck_e.fend;
        end
        tx_log.push_back(bus.tx_data);
        outstanding = 1'b1;
        delay = int'($urandom_range(1, 4));
      end else begin
        chk("err_len_idle", 16'(err_len), 16'd0);
        if (outstanding) begin
          chk("tx_data_hold", 16'(bus.tx_data), 16'(cur_byte));
          chk("busy_while_sending", 16'(busy), 16'd1);
        end
      end
      if (outstanding || (cyc > fin_cyc && cyc < done_due))
        chk("in_ready_low", 16'(bus.in_ready), 16'd0);

      if (bus.tx_data_f) begin
        bus.tx_send_finish = 1'b0;
      end else if (outstanding) begin
        if (delay == 0) begin
          bus.tx_send_finish = 1'b1;
          outstanding = 1'b0;
          if (cur_end) begin
            fin_cyc  = cyc;
            done_due = cyc + DONE_LAT;
          end
        end else begin
          delay--;
          bus.tx_send_finish = 1'b0;
        end
      end else begin
        // Spurious finish pulses while idle or in the silence gap must be ignored.
        bus.tx_send_finish = (!busy || (cyc > fin_cyc && cyc < done_due - 1)) &&
                             ($urandom_range(0, 7) == 0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit l);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_timeout", 16'(t >= 3000), 16'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drive_plan(input bit rand_idle);
    foreach (plan[i]) begin
      if (rand_idle) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(plan[i].d, plan[i].l);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 20000; t++) begin
      if (exp_q.size() == 0 && !outstanding && cyc > done_due + 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drain_timeout", 16'(ok), 16'd1);
  endtask

  initial begin
    logic [7:0] lit[8];
    logic [7:0] q6[$];
    int len, strobes, fdn;

    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.tx_send_finish = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_tx_data", 16'(bus.tx_data), 16'h00);
    chk("rst_tx_data_f", 16'(bus.tx_data_f), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_frame_done", 16'(frame_done), 16'd0);
    chk("rst_err_len", 16'(err_len), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 16'(bus.in_ready), 16'd1);

    // Directed frames followed by random ones
    lit = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    for (int i = 0; i < 6; i++) begin
      plan.push_back('{d: lit[i], l: (i == 5)});
      q6.push_back(lit[i]);
    end
    chk("model_crc_0103", crc_fn(q6), 16'h0A84);
    plan.push_back('{d: 8'h55, l: 1'b1});
    for (int i = 0; i < 7; i++) plan.push_back('{d: 8'(8'h10 + i), l: 1'b0});
    plan.push_back('{d: 8'h17, l: 1'b1});
    for (int f = 0; f < 12; f++) begin
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) plan.push_back('{d: 8'($urandom), l: (i == len - 1)});
    end
    build_model();
    chk("model_crc_lo", 16'(exp_q[6].data), 16'h0084);
    chk("model_crc_hi", 16'(exp_q[7].data), 16'h000A);
    chk("model_trunc_err", 16'(exp_q[16].err), 16'd1);

    chk_en = 1'b1;
    drive_plan(1'b1);
    drain();
    chk_en = 1'b0;
    bus.tx_send_finish = 1'b0;

    for (int i = 0; i < 8; i++) chk("frame1_byte", 16'(tx_log[i]), 16'(lit[i]));
    chk("single_byte_payload", 16'(tx_log[8]), 16'h0055);
    chk("seventh_byte_new_frame", 16'(tx_log[19]), 16'h0016);

    // Reset while waiting for the finish of byte 3
    @(negedge clk);
    send(8'hA1, 1'b0);
    @(negedge clk); bus.tx_send_finish = 1'b1;
    @(negedge clk); bus.tx_send_finish = 1'b0;
    send(8'hA2, 1'b0);
    @(negedge clk); bus.tx_send_finish = 1'b1;
    @(negedge clk); bus.tx_send_finish = 1'b0;
    send(8'hA3, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", 16'(busy), 16'd1);
    chk("pre_rst_tx_data", 16'(bus.tx_data), 16'h00A3);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_data", 16'(bus.tx_data), 16'h00);
    chk("midrst_tx_data_f", 16'(bus.tx_data_f), 16'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("midrst_frame_done", 16'(frame_done), 16'd0);
    chk("midrst_err_len", 16'(err_len), 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    fdn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.tx_data_f) strobes++;
      if (frame_done) fdn++;
    end
    chk("no_crc_after_reset", 16'(strobes), 16'd0);
    chk("no_done_after_reset", 16'(fdn), 16'd0);

    // Fresh frame after the reset
    plan.delete();
    for (int i = 0; i < 6; i++) plan.push_back('{d: lit[i], l: (i == 5)});
    build_model();
    outstanding = 1'b0;
    fin_cyc = -100000;
    done_due = -100000;
    chk_en = 1'b1;
    drive_plan(1'b0);
    drain();
    chk_en = 1'b0;

    chk("frame_done_count", 16'(n_fd_seen), 16'(n_frames_exp));
    chk("err_len_count", 16'(n_err_seen), 16'(n_err_exp));
    for (int i = 0; i < 8; i++)
      chk("post_rst_byte", 16'(tx_log[tx_log.size() - 8 + i]), 16'(lit[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
